// File: rtl/dht_reader_pkg.sv
// Shared types and helpers for the DHT22-class single-wire sensor reader.
// Holds the FSM state encoding, frame size and frame checksum.
package dht_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_LOW,
        RELEASE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } state_e;

    localparam int FRAME_BITS = 40;

    function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

endpackage

// File: rtl/dht_reader_us_tick_gen.sv
// Free-running 1 us and 1 ms strobe generator derived from CLK_HZ.
// Reusable by any sensor block that times its phases in microseconds.
module us_tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic us_tick_o,
    output logic ms_tick_o
);

    localparam int DIV = (CLK_HZ / 1000000 > 1) ? CLK_HZ / 1000000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_q, div_d;
    logic [9:0]    ms_q, ms_d;

    assign us_tick_o = (div_q == CW'(DIV - 1));
    assign ms_tick_o = us_tick_o && (ms_q == 10'd999);

    always_comb begin
        div_d = us_tick_o ? '0 : div_q + 1'b1;
        ms_d  = ms_q;
        if (us_tick_o) begin
            ms_d = ms_tick_o ? '0 : ms_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            ms_q  <= '0;
        end else begin
            div_q <= div_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/dht_reader.sv
// DHT22-class reader: polls the sensor, decodes a 40-bit pulse-width frame,
// and publishes it on a stable register only after the checksum matches.
import dht_reader_pkg::*;

module dht_reader #(
    parameter int CLK_HZ        = 50000000,
    parameter int START_LOW_US  = 1000,
    parameter int POLL_MS       = 2000,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dht_in,
    output logic                  dht_drive_low,
    output logic [FRAME_BITS-1:0] hym_data,
    output logic                  data_valid,
    output logic                  crc_err,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int TMAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int TW   = $clog2(TMAX + 2);
    localparam int PW   = $clog2(POLL_MS + 1);

    logic us_tick, ms_tick;

    us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .us_tick_o (us_tick),
        .ms_tick_o (ms_tick)
    );

    logic                  sync1_q, sync2_q, prev_q;
    logic                  rise, fall, waiting;
    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d, elapsed;
    logic [PW-1:0]         poll_q, poll_d;
    logic [5:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] shadow_q, shadow_d, hym_q, hym_d;
    logic                  dv_q, dv_d, crc_q, crc_d, to_q, to_d;

    assign rise    = sync2_q & ~prev_q;
    assign fall    = ~sync2_q & prev_q;
    // Count including the tick of this cycle, so a phase of N us reads N.
    assign elapsed = timer_q + TW'(us_tick);
    assign waiting = state_q inside {RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};

    always_comb begin
        state_d  = state_q;
        timer_d  = (state_q == IDLE) ? '0 : elapsed;
        poll_d   = poll_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        hym_d    = hym_q;
        dv_d     = 1'b0;
        crc_d    = 1'b0;
        to_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ms_tick) poll_d = poll_q + 1'b1;
                if (start || (ms_tick && poll_q == PW'(POLL_MS - 1))) begin
                    state_d = START_LOW;
                    poll_d  = '0;
                end
            end
            START_LOW: if (elapsed == TW'(START_LOW_US)) state_d = RELEASE;
            RELEASE:   if (fall) state_d = RESP_LOW;
            RESP_LOW:  if (rise) state_d = RESP_HIGH;
            RESP_HIGH: begin
                if (fall) begin
                    state_d = BIT_LOW;
                    bit_d   = '0;
                end
            end
            BIT_LOW:   if (rise) state_d = BIT_HIGH;
            BIT_HIGH: begin
                if (fall) begin
                    shadow_d = {shadow_q[FRAME_BITS-2:0], elapsed > TW'(BIT_THRESH_US)};
                    if (bit_q == 6'(FRAME_BITS - 1)) begin
                        state_d = CHECK;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        state_d = BIT_LOW;
                    end
                end
            end
            CHECK: begin
                if (frame_sum(shadow_q) == shadow_q[7:0]) begin
                    hym_d = shadow_q;
                    dv_d  = 1'b1;
                end else begin
                    crc_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (waiting && state_d == state_q && elapsed >= TW'(TIMEOUT_US)) begin
            state_d = IDLE;
            to_d    = 1'b1;
        end
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= IDLE;
            timer_q  <= '0;
            poll_q   <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            hym_q    <= '0;
            dv_q     <= 1'b0;
            crc_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            sync1_q  <= dht_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            timer_q  <= timer_d;
            poll_q   <= poll_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            hym_q    <= hym_d;
            dv_q     <= dv_d;
            crc_q    <= crc_d;
            to_q     <= to_d;
        end
    end

    assign hym_data      = hym_q;
    assign data_valid    = dv_q;
    assign crc_err       = crc_q;
    assign timeout_err   = to_q;
    assign dht_drive_low = (state_q == START_LOW);
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/dht_reader.md
Name: dht_reader

Overview:
- Single-wire humidity/temperature sensor front end (DHT22-class, 40-bit frame).
- Polls the sensor periodically, decodes 40 pulse-width-coded bits and verifies the checksum.
- Presents the frame on a stable 40-bit register that feeds the SPI slave's humidity input vector directly.
- The register updates only on a good frame, in a single cycle, so the SPI side may sample it at any time.

Parameters:
- CLK_HZ, 50000000, system clock frequency; a 1 us tick is derived from it.
- START_LOW_US, 1000, host start-pulse low time (18000 for DHT11 parts).
- POLL_MS, 2000, interval between automatic reads.
- BIT_THRESH_US, 40, a data-high pulse longer than this decodes as 1.
- TIMEOUT_US, 200, maximum duration of any single line phase after start.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle manual trigger; ignored while busy.
- dht_in  in  1  sensor line as read from the pad (asynchronous).
- dht_drive_low  out  1  1 = pad driver pulls the line low; 0 = released (external pull-up).
- hym_data  out  40  last good frame, byte0 in [39:32], checksum in [7:0].
- data_valid  out  1  one-cycle pulse when hym_data is updated.
- crc_err  out  1  one-cycle pulse when a frame fails the checksum.
- timeout_err  out  1  one-cycle pulse when a phase exceeds TIMEOUT_US.
- busy  out  1  high from START_LOW entry until return to IDLE.

Behaviour:
- Reset values: hym_data=0, all pulses 0, dht_drive_low=0, busy=0, state IDLE, poll timer=0, us timer=0.
- Reset is asynchronous and active-high; one clock; every flop on clk.
- dht_in is passed through a 2-flop synchroniser. Edges are detected on the synchronised value, giving 2-3 cycles of latency, which is ignored in timing.
- us tick: one-cycle pulse every CLK_HZ/1000000 clocks. All phase timers count ticks and are cleared on each state change.
- IDLE:
  - The poll timer counts ms.
  - When it reaches POLL_MS or start=1, go to START_LOW and clear the poll timer.
  - If both occur in the same cycle, only one read starts.
- START_LOW: dht_drive_low=1 for START_LOW_US, then go to RELEASE.
- RELEASE: dht_drive_low=0; wait for the line to go low (sensor response) -> RESP_LOW.
- RESP_LOW: wait for the rising edge -> RESP_HIGH.
- RESP_HIGH: wait for the falling edge -> BIT_LOW, with bit_idx=0.
- BIT_LOW: wait for the rising edge -> BIT_HIGH and clear the timer.
- BIT_HIGH: on the falling edge:
  - Shift a bit into a 40-bit shadow register, MSB first: bit = (timer > BIT_THRESH_US).
  - If bit_idx==39 go to CHECK, else increment bit_idx and go to BIT_LOW.
- CHECK, one cycle:
  - sum = (b0+b1+b2+b3) mod 256, where b0=shadow[39:32].
  - If sum==shadow[7:0]: load hym_data<=shadow and pulse data_valid.
  - Otherwise pulse crc_err and leave hym_data unchanged.
  - Then go to IDLE.
- Timeout: in any state from RELEASE to BIT_HIGH, if the timer reaches TIMEOUT_US, pulse timeout_err, release the line and go to IDLE. hym_data is unchanged and the shadow is discarded.
- Sensor pull-low during START_LOW is not checked; the line is driven by the host.
- Reset mid-frame: the line is released immediately and the frame is lost.
- start while busy: no effect and not queued.
- Counter widths: sized for the largest of START_LOW_US, TIMEOUT_US and POLL_MS; no wrap is permitted within any phase.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK);
  - FRAME_BITS=40;
  - a checksum function.
- Sub-module us_tick_gen (parameter CLK_HZ; outputs us_tick and ms_tick) is reusable by other sensor blocks.

Test Plan:
- All scenarios use CLK_HZ=1000000. The sensor model replies 30 us after release, then 80 us low and 80 us high. Each bit is 50 us low, then 27 us high for 0 or 70 us high for 1.
- Good frame: start pulse; model sends 02 8C 01 5F EE -> after the last falling edge, one data_valid pulse, hym_data=40'h028C015FEE, busy falls, dht_drive_low was high for 1000 ticks.
- Bad checksum: model sends 02 8C 01 5F EF after the good frame -> crc_err pulses, no data_valid, hym_data stays 40'h028C015FEE.
- No sensor: line held high after release -> timeout_err at 200 us into RELEASE, dht_drive_low=0, back to IDLE, hym_data unchanged.
- Stuck bit: model holds the line high at bit 17 -> timeout_err after 200 us; the next good frame 01 90 00 F0 81 decodes to 40'h019000F081.
- Threshold edges: high pulses of 40 us decode to 0 and 41 us to 1. Frame 00 00 00 01 01 built with a 41 us final-byte pulse -> data_valid, hym_data=40'h0000000101.
- Control/reset:
  - start asserted while busy -> no second START_LOW.
  - POLL_MS=5 with no start -> START_LOW entered every 5 ms plus frame time.
  - rst asserted mid-BIT_HIGH -> outputs return to reset values asynchronously.
